// File: rtl/data_memory_if.sv
// data_memory_if: bus between the MEM stage and the data memory
// addr  word address, rw_rd 0=write 1=read, din write data, dout registered read data
interface data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rw_rd;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  modport master (output addr, rw_rd, din, input dout);
  modport slave  (input addr, rw_rd, din, output dout);
endinterface

// File: rtl/data_memory.sv
// data_memory: word-addressed single-port RAM with registered read and per-word valid bits
// clk clock, rst_n async active-low reset (clears dout and valid bits), bus slave port
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic           clk,
  input logic           rst_n,
  data_memory_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  // An X/Z rw_rd fails the == 0 test and so falls through to a read.
  always_ff @(posedge clk)
    if (rst_n && bus.rw_rd == 1'b0) mem[bus.addr] <= bus.din;
  // Valid bits make never-written words read as zero without clearing the array.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid   <= '0;
      bus.dout <= '0;
    end else if (bus.rw_rd == 1'b0) valid[bus.addr] <= 1'b1;
    else bus.dout <= valid[bus.addr] ? mem[bus.addr] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed plus random checks of data_memory against an array model
module tb_data_memory;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [1024];
  bit mv [1024];
  logic [31:0] exp_dout;
  data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();
  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag);
    checks++;
    assert (bus.dout === exp_dout) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, bus.dout, exp_dout);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
    exp_dout = '0;
  endtask
  task automatic op(input bit rw, input int a, input logic [31:0] d, input string tag);
    bus.rw_rd = rw;
    bus.addr  = a[9:0];
    bus.din   = d;
    @(posedge clk);
    #1;
    if (rw) exp_dout = mv[a] ? model[a] : 32'h0;
    else begin
      model[a] = d;
      mv[a]    = 1'b1;
    end
    chk(tag);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.rw_rd = 1'b0;
    bus.addr = 10'd5;
    bus.din = 32'h1234_5678;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout");
    bus.rw_rd = 1'b1;
    rst_n = 1'b1;
    op(1, 5, 0, "write_during_reset_ignored");
    for (int i = 0; i < 15; i++) op(0, i, i, "write_sweep_dout_hold");
    for (int i = 0; i < 15; i++) op(1, i, 0, "read_sweep");
    op(1, 100, 0, "unwritten_100");
    op(0, 1023, 32'hDEAD_BEEF, "write_1023");
    op(1, 1023, 0, "read_1023");
    op(0, 3, 32'h5, "ow_first");
    op(0, 3, 32'hA, "ow_second");
    op(1, 3, 0, "read_overwrite");
    op(0, 4, 32'h77, "write_holds_dout");
    op(0, 5, 32'h88, "write_holds_dout2");
    bus.rw_rd = 1'b1;
    bus.addr = 10'd3;
    #3;
    bus.addr = 10'd7;
    #1;
    chk("between_edge_change_no_effect");
    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? 1023 - $urandom_range(0, 3) : $urandom_range(0, 31);
      op(bit'($urandom_range(0, 1)), a, $urandom, "random_op");
    end
    op(0, 7, 32'hCAFE_F00D, "pre_reset_write");
    op(1, 7, 0, "pre_reset_read");
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("async_reset_dout");
    #1;
    rst_n = 1'b1;
    op(1, 7, 0, "read_after_reset_7");
    op(1, 1023, 0, "read_after_reset_1023");
    op(0, 7, 32'h0BAD_CAFE, "rewrite_7");
    op(1, 7, 0, "reread_7");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
